// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM/WB pipeline register with 2-entry skid buffer, flush and stall counter
module mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_lwsrc,
  input  logic [ADDR_W-1:0] in_write_addr,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_dm_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_lwsrc,
  output logic [ADDR_W-1:0] out_write_addr,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_dm_data,
  output logic [DATA_W-1:0] out_wb_data,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding chosen so bit 0 is the main valid and bit 1 the skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic              accept, send;
  logic              ld_main_in, ld_main_skid, ld_skid, clr_skid;
  logic              main_reg_write;
  logic              skid_lwsrc;
  logic [ADDR_W-1:0] skid_write_addr;
  logic              skid_reg_write;
  logic [DATA_W-1:0] skid_result;
  logic [DATA_W-1:0] skid_dm_data;

  assign out_valid = state[0];
  assign in_ready  = ~state[1];
  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt  = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && send) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          ld_skid   = 1'b1;
        end else if (send) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (send) begin
          state_nxt    = ONE;
          ld_main_skid = 1'b1;
          clr_skid     = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over any accept; a concurrent send has already been taken by WB.
    if (flush) begin
      state_nxt    = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      clr_skid     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_lwsrc      <= 1'b0;
      out_write_addr <= '0;
      main_reg_write <= 1'b0;
      out_result     <= '0;
      out_dm_data    <= '0;
    end else if (ld_main_in) begin
      out_lwsrc      <= in_lwsrc;
      out_write_addr <= in_write_addr;
      main_reg_write <= in_reg_write;
      out_result     <= in_result;
      out_dm_data    <= in_dm_data;
    end else if (ld_main_skid) begin
      out_lwsrc      <= skid_lwsrc;
      out_write_addr <= skid_write_addr;
      main_reg_write <= skid_reg_write;
      out_result     <= skid_result;
      out_dm_data    <= skid_dm_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_lwsrc      <= 1'b0;
      skid_write_addr <= '0;
      skid_reg_write  <= 1'b0;
      skid_result     <= '0;
      skid_dm_data    <= '0;
    end else if (ld_skid) begin
      skid_lwsrc      <= in_lwsrc;
      skid_write_addr <= in_write_addr;
      skid_reg_write  <= in_reg_write;
      skid_result     <= in_result;
      skid_dm_data    <= in_dm_data;
    end else if (clr_skid) begin
      skid_lwsrc      <= 1'b0;
      skid_write_addr <= '0;
      skid_reg_write  <= 1'b0;
      skid_result     <= '0;
      skid_dm_data    <= '0;
    end
  end

  assign out_reg_write = main_reg_write & out_valid;
  assign out_wb_data   = out_lwsrc ? out_dm_data : out_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (clr_stats)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb/tb_mem_wb_skid.sv - scoreboard bench for mem_wb_skid (counter width 2 to reach saturation)
module tb_mem_wb_skid;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  typedef struct {
    logic              lwsrc;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] dm;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_lwsrc;
  logic [ADDR_W-1:0] in_write_addr;
  logic              in_reg_write;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_dm_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_lwsrc;
  logic [ADDR_W-1:0] out_write_addr;
  logic              out_reg_write;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_dm_data;
  logic [DATA_W-1:0] out_wb_data;
  logic              clr_stats;
  logic [CNT_W-1:0]  stall_cnt;

  entry_t     sb[$];
  logic [CNT_W-1:0] exp_cnt;
  int         n_cmp  = 0;
  int         n_fail = 0;

  mem_wb_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_lwsrc(in_lwsrc),
    .in_write_addr(in_write_addr), .in_reg_write(in_reg_write),
    .in_result(in_result), .in_dm_data(in_dm_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lwsrc(out_lwsrc),
    .out_write_addr(out_write_addr), .out_reg_write(out_reg_write),
    .out_result(out_result), .out_dm_data(out_dm_data), .out_wb_data(out_wb_data),
    .clr_stats(clr_stats), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic v, input logic lw, input logic [ADDR_W-1:0] a,
                       input logic rw, input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] dm);
    in_valid      = v;
    in_lwsrc      = lw;
    in_write_addr = a;
    in_reg_write  = rw;
    in_result     = res;
    in_dm_data    = dm;
  endtask

  // One clock: predict from pre-edge signals, then check the scoreboard after the edge.
  task automatic tick();
    logic acc, snd;
    logic [DATA_W-1:0] res_s, wb_s;
    logic [ADDR_W-1:0] addr_s;
    logic rw_s;
    entry_t e, ni;
    logic exp_rw;
    acc    = in_valid & in_ready;
    snd    = out_valid & out_ready;
    res_s  = out_result;
    wb_s   = out_wb_data;
    addr_s = out_write_addr;
    rw_s   = out_reg_write;
    ni.lwsrc = in_lwsrc; ni.addr = in_write_addr; ni.rw = in_reg_write;
    ni.result = in_result; ni.dm = in_dm_data;
    if (clr_stats) exp_cnt = '0;
    else if (out_valid && !out_ready && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
    if (snd) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_send: got result=%h, required no entry", res_s);
      end else begin
        e = sb.pop_front();
        n_cmp += 3;
        if (res_s !== e.result) begin
          n_fail++; $display("FAIL send_result: got %h required %h", res_s, e.result);
        end
        if (wb_s !== (e.lwsrc ? e.dm : e.result)) begin
          n_fail++; $display("FAIL send_wb_data: got %h required %h", wb_s, e.lwsrc ? e.dm : e.result);
        end
        if (addr_s !== e.addr || rw_s !== e.rw) begin
          n_fail++; $display("FAIL send_addr_rw: got %h/%b required %h/%b", addr_s, rw_s, e.addr, e.rw);
        end
      end
    end
    if (acc) sb.push_back(ni);
    if (flush) sb.delete();
    exp_rw = (sb.size() > 0) ? sb[0].rw : 1'b0;
    n_cmp += 4;
    if (stall_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, exp_cnt);
    end
    if (out_valid !== (sb.size() > 0)) begin
      n_fail++; $display("FAIL out_valid: got %b required %b", out_valid, sb.size() > 0);
    end
    if (in_ready !== (sb.size() < 2)) begin
      n_fail++; $display("FAIL in_ready: got %b required %b", in_ready, sb.size() < 2);
    end
    if (out_reg_write !== exp_rw) begin
      n_fail++; $display("FAIL out_reg_write: got %b required %b", out_reg_write, exp_rw);
    end
    if (sb.size() > 0) begin
      n_cmp++;
      if (out_result !== sb[0].result) begin
        n_fail++; $display("FAIL head_result: got %h required %h", out_result, sb[0].result);
      end
    end
  endtask

  task automatic test_reset();
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt); end
    if (out_wb_data !== '0 || out_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_payload: got wb=%h rw=%b required 0/0", out_wb_data, out_reg_write);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd7, 1'b1, 32'h77, 32'h0); tick();
    drive(1'b1, 1'b0, 5'd8, 1'b1, 32'h88, 32'h0); tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
    if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL midrst_reg_write: got %b required 0", out_reg_write); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL midrst_stall_cnt: got %0d required 0", stall_cnt); end
    sb.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, ADDR_W'(i + 1), 1'b1, 32'h11 * (i + 1), 32'hFFFF_0000 + i);
      tick();
      if (i == 0) begin
        n_cmp++;
        if (out_wb_data !== 32'h11) begin
          n_fail++; $display("FAIL stream_latency: got %h required 00000011", out_wb_data);
        end
      end
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
  endtask

  task automatic test_back_pressure();
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd10, 1'b1, 32'hA, 32'h0); tick();
    drive(1'b1, 1'b0, 5'd11, 1'b0, 32'hB, 32'h0); tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b required 0", in_ready); end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    out_ready = 1'b1;
    tick();
    n_cmp += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after_a: got %b required 1", in_ready); end
    if (out_result !== 32'hB) begin n_fail++; $display("FAIL bp_b_next: got %h required 0000000b", out_result); end
    tick();
    tick();
  endtask

  task automatic test_load_select();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 1'b1, 32'h5, 32'hDEAD_BEEF); tick();
    n_cmp++;
    if (out_wb_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_sel_dm: got %h required deadbeef", out_wb_data); end
    drive(1'b1, 1'b0, 5'd3, 1'b1, 32'h5, 32'hDEAD_BEEF); tick();
    n_cmp++;
    if (out_wb_data !== 32'h5) begin n_fail++; $display("FAIL ld_sel_result: got %h required 00000005", out_wb_data); end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd20, 1'b1, 32'hF1, 32'h0); tick();
    drive(1'b1, 1'b0, 5'd21, 1'b1, 32'hF2, 32'h0); tick();
    flush = 1'b1;
    drive(1'b1, 1'b0, 5'd22, 1'b1, 32'hF3, 32'h0);
    tick();
    flush = 1'b0;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b required 0", out_valid); end
    if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_reg_write: got %b required 0", out_reg_write); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b required 1", in_ready); end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_counter();
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd30, 1'b1, 32'h3, 32'h33); tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (stall_cnt !== 2'd3) begin n_fail++; $display("FAIL cnt_saturate: got %0d required 3", stall_cnt); end
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    n_cmp++;
    if (stall_cnt !== 2'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d required 0", stall_cnt); end
    out_ready = 1'b1;
    tick(); tick();
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    exp_cnt   = '0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    #1;
    test_reset();
    test_reset_midop();
    test_streaming();
    test_back_pressure();
    test_load_select();
    test_flush();
    test_counter();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL leftover_entries: got %0d required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised successor to the MEM/WB pipeline register.
- Carries the writeback payload (load-select, destination register, write-enable, ALU/move result, data-memory read data) from MEM to WB.
- Adds a valid/ready handshake with a 2-entry skid buffer, so WB back-pressure never drops an instruction. Also adds synchronous flush, an integrated writeback data select, and a saturating stall counter.
- Sits between the MEM-stage result mux / data memory and the register-file write port.

Parameters:
DATA_W  32  width of result, DM read data and writeback data
ADDR_W  5  register-file address width
CNT_W  16  width of stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
flush  in  1  synchronous kill of all held entries
in_valid  in  1  MEM stage presents a valid instruction
in_ready  out  1  stage can accept this cycle (registered)
in_lwsrc  in  1  0 = writeback ALU/move result, 1 = writeback load data
in_write_addr  in  ADDR_W  destination register
in_reg_write  in  1  instruction writes the register file
in_result  in  DATA_W  ALU/move mux result
in_dm_data  in  DATA_W  data-memory read data
out_valid  out  1  WB entry valid
out_ready  in  1  WB consumes the entry this cycle
out_lwsrc  out  1  registered lwsrc
out_write_addr  out  ADDR_W  registered destination
out_reg_write  out  1  register-file write enable, qualified by out_valid
out_result  out  DATA_W  registered result
out_dm_data  out  DATA_W  registered DM data
out_wb_data  out  DATA_W  out_lwsrc ? out_dm_data : out_result (combinational from registers)
clr_stats  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (async, rst=1), all applied immediately:
  - State EMPTY; main and skid valid = 0.
  - out_valid=0, in_ready=1, out_lwsrc=0, out_write_addr=0, out_reg_write=0, out_result=0, out_dm_data=0, out_wb_data=0, stall_cnt=0.
  - Skid payload = 0.
- Definitions: accept = in_valid & in_ready; send = out_valid & out_ready.
- Output registers always reflect the main entry. out_valid = main valid. in_ready = !skid valid.
- State machine:
  - EMPTY:
    - accept -> ONE, main <= in.
    - otherwise stay EMPTY.
  - ONE:
    - accept & send -> ONE, main <= in.
    - accept & !send -> FULL, skid <= in.
    - !accept & send -> EMPTY.
    - neither -> hold.
  - FULL (in_ready=0, so no accept):
    - send -> ONE, main <= skid, skid cleared.
    - otherwise hold both entries.
- Latency: accept at edge N -> out_valid=1 after edge N, i.e. 1 cycle. Throughput is 1 per cycle while out_ready=1.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- out_reg_write = main.reg_write & out_valid. A bubble never writes the register file.
- Payload outputs other than out_reg_write hold their last value while out_valid=0.
- Flush (sync):
  - Next state EMPTY, both valids cleared, in_ready=1 next cycle.
  - Flush has priority over a simultaneous accept; the accepted data is discarded.
  - A simultaneous send still counts as consumed by WB.
- Stall counter:
  - Increments on each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1.
  - clr_stats sets it to 0 and takes priority over an increment in the same cycle.
  - Flush does not clear it.
- Reset mid-operation: all entries lost immediately, outputs at reset values. First accept is possible on the first edge after rst deasserts.
- No combinational path from out_ready to in_ready (in_ready comes from a flop).

Test Plan:
- Reset → outputs:
  - Stimulus: assert rst mid-cycle with FULL state.
  - Required: out_valid=0, out_reg_write=0, in_ready=1, stall_cnt=0 immediately, without waiting for a clock edge.
- Streaming:
  - Stimulus: out_ready=1, in_valid=1 for 4 cycles with results 0x11, 0x22, 0x33, 0x44, lwsrc=0, reg_write=1, addr=1..4.
  - Required: identical sequence on out_result/out_wb_data, each 1 cycle later, with out_reg_write=1 on each.
- Back-pressure:
  - Stimulus: out_ready=0, push A then B.
  - Required: in_ready=0 after B; stall_cnt increments each stalled cycle.
  - Stimulus: raise out_ready.
  - Required: A then B delivered on consecutive cycles, in_ready=1 after A leaves.
- Load select:
  - Stimulus: in_lwsrc=1, in_dm_data=0xDEADBEEF, in_result=0x5.
  - Required: out_wb_data=0xDEADBEEF.
  - Stimulus: same entry with lwsrc=0.
  - Required: out_wb_data=0x5.
- Flush:
  - Stimulus: in FULL, assert flush together with in_valid.
  - Required: next cycle out_valid=0, out_reg_write=0, in_ready=1; neither held entry nor the new entry ever appears.
- Counter:
  - Stimulus: CNT_W=2, stall 5 cycles.
  - Required: stall_cnt=3 (saturated).
  - Stimulus: clr_stats asserted during a stall.
  - Required: stall_cnt=0.
